// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath blocks: default register-file
// geometry and the hard-wired zero register address.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the register file.
// Selects the addressed word, optionally forwards the in-flight write
// (macro REG_FILE_BYPASS_EN), and always returns zero for the zero register.
module reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

`ifndef REG_FILE_BYPASS_EN
    // Write-side inputs only matter when forwarding is built in.
    logic unused_wr;
    assign unused_wr = &{1'b0, wr_en, wr_addr, wr_data};
`endif

    // Stored value, optionally overridden by the same-cycle write, zero forced last.
    always_comb begin
        data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (addr == wr_addr)) begin
            data = wr_data;
        end
`endif
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// write port committed on the rising clock edge, register 0 hard-wired to
// zero, and a running count of committed writes.
// Optional same-cycle write forwarding on the read ports: macro REG_FILE_BYPASS_EN.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Read_Register1,
    input  logic [ADDR_W-1:0] Read_Register2,
    input  logic [ADDR_W-1:0] Write_Register,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic [31:0]       Write_Count
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;

    // An unknown RegWrite evaluates false here, so it never commits.
    assign wr_commit = (RegWrite == 1'b1) && !reset &&
                       (Write_Register != ADDR_W'(REG_ZERO));

    // Register storage and write counter; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            Write_Count <= '0;
        end else if (wr_commit) begin
            regs[Write_Register] <= Write_Data;
            Write_Count          <= Write_Count + 32'd1;
        end
    end

`ifndef SYNTHESIS
    // Report an unknown write enable seen at a clock edge.
    always @(posedge clk) begin
        if (!reset && $isunknown(RegWrite)) begin
            $display("reg_file: RegWrite=%b at clock edge, treated as no write", RegWrite);
        end
    end
`endif

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .addr    (Read_Register1),
        .regs    (regs),
        .wr_en   (wr_commit),
        .wr_addr (Write_Register),
        .wr_data (Write_Data),
        .data    (Read_Data1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .addr    (Read_Register2),
        .regs    (regs),
        .wr_en   (wr_commit),
        .wr_addr (Write_Register),
        .wr_data (Write_Data),
        .data    (Read_Data2)
    );

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register and data width.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 SHALL provide clk  input  1  single clock; all writes occur on its rising edge.
REQ-004 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide Read_Register1  input  ADDR_W  read port 1 address (instruction[25:21]).
REQ-006 SHALL provide Read_Register2  input  ADDR_W  read port 2 address (instruction[20:16]).
REQ-007 SHALL provide Write_Register  input  ADDR_W  destination address, driven by the RegDst mux.
REQ-008 SHALL provide Write_Data  input  DATA_W  write-back value, driven by the MemtoReg MUX_32.
REQ-009 SHALL provide RegWrite  input  1  write enable.
REQ-010 SHALL provide Read_Data1  output  DATA_W  port 1 data.
REQ-011 SHALL provide Read_Data2  output  DATA_W  port 2 data.
REQ-012 SHALL provide Write_Count  output  32  number of committed writes since reset.

Function
REQ-013 SHALL commit Write_Data to register Write_Register at a rising clk edge when RegWrite==1, reset==0, and Write_Register!=0.
REQ-014 SHALL read both ports combinationally, with zero cycles of latency from address to data.
REQ-015 SHALL always return 0 for address 0; a write to address 0 is discarded and not counted.
REQ-016 SHALL treat RegWrite X/Z at a clock edge as no write and issue a simulation $display reporting the value.
REQ-017 SHALL increment Write_Count by 1 per committed write, wrapping from 0xFFFFFFFF to 0.
REQ-018 SHALL serve both ports from the same address in the same cycle with identical data.
REQ-019 SHALL, for back-to-back writes to the same register, hold the last value written; every committed write SHALL be counted.

Reset
REQ-020 SHALL clear all registers, Read_Data1, Read_Data2 and Write_Count to 0 immediately on reset assertion, without waiting for a clock edge.
REQ-021 SHALL ignore writes while reset is high, including a write whose clock edge coincides with reset deassertion.
REQ-022 SHALL accept a write at the first rising edge after reset deasserts.

Configuration
REQ-023 SHALL support the macro REG_FILE_BYPASS_EN.
REQ-024 With REG_FILE_BYPASS_EN defined, a read whose address equals a nonzero Write_Register while RegWrite==1 SHALL return Write_Data in the same cycle.
REQ-025 Without REG_FILE_BYPASS_EN, such a read SHALL return the stored (old) value until after the clock edge.

Structure
REQ-026 SHALL take DATA_W/ADDR_W defaults and the REG_ZERO constant (5'd0) from the shared package mips_pkg.
REQ-027 SHALL implement each read port, including zero forcing and the optional bypass, in a sub-module reg_read_port instantiated twice.

Verification
REQ-028 Reset, then read all 32 addresses: all return 0, and Write_Count==0.
REQ-029 Write 0xDEADBEEF to reg 8 with RegWrite=1, then read reg 8 on both ports the next cycle: both return 0xDEADBEEF, and Write_Count==1.
REQ-030 Write 0x12345678 to reg 0: reads of reg 0 return 0, and Write_Count is unchanged.
REQ-031 Read reg 9 (holding 0x1) while writing 0x2 to reg 9 in the same cycle: the read returns 0x2 with REG_FILE_BYPASS_EN and 0x1 without it.
REQ-032 Assert reset mid-sequence after 3 writes: all outputs are 0 before the next edge, and the write at the deassertion edge is ignored.
REQ-033 Drive RegWrite=1'bx with Write_Register=5, Write_Data=0xFF: reg 5 is unchanged, a $display is printed, and Write_Count is unchanged.
